// File: rtl/rnc_input_feeder_pkg.sv
// Shared types for the RANC input feeder: packet layout and tick-sequencer states.
package rnc_input_feeder_pkg;

  localparam int RNC_PACKET_WIDTH = 30;

  // Routing packet as seen on the grid west port, MSB first.
  typedef struct packed {
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [7:0]        axon;
    logic [3:0]        tick;
  } rnc_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TICK   = 3'd3,
    ST_GAP    = 3'd4
  } feeder_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rnc_input_feeder_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head and occupancy count.
module rnc_input_feeder_sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d, remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_q;

  // The head register is reloaded with whatever will be at the front after this edge;
  // when no older entry survives the pop, the word being pushed becomes the head.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    head_d  = head_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    remain  = count_q - CW'(pop_ok);
    if (remain != '0)  head_d = mem[rd_d];
    else if (push_ok)  head_d = data_i;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      empty_q <= 1'b1;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      empty_q <= (count_d == '0);
    end
  end

  assign data_o      = head_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign full_next_o = (count_d == CW'(DEPTH));

endmodule

// File: rtl/rnc_input_feeder.sv
// Host-to-grid packet feeder: FWFT packet buffer plus the frame/tick sequencer
// (drain, settle, one-cycle tick, then a hold-off window for neuron processing).
module rnc_input_feeder
  import rnc_input_feeder_pkg::*;
#(
  parameter int PACKET_WIDTH    = RNC_PACKET_WIDTH,
  parameter int FIFO_DEPTH      = 64,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TICK_GAP_CYCLES = 300,
  parameter int TICK_CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PACKET_WIDTH-1:0]     in_packet,
  input  logic                        tick_req,
  output logic [PACKET_WIDTH-1:0]     packet_out,
  output logic                        buffer_empty,
  input  logic                        ren,
  input  logic                        grid_drained,
  output logic                        tick,
  output logic                        busy,
  output logic [TICK_CNT_W-1:0]       tick_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underflow_error
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int GW = cnt_w(TICK_GAP_CYCLES);

  feeder_state_e         state_q, state_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  in_ready_q, tick_q, busy_q, underflow_q;
  logic [TICK_CNT_W-1:0] tick_count_q;
  logic                  full_next;

  rnc_input_feeder_sync_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid && in_ready_q),
    .pop_i       (ren),
    .data_i      (in_packet),
    .data_o      (packet_out),
    .empty_o     (buffer_empty),
    .count_o     (fifo_count),
    .full_next_o (full_next)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    unique case (state_q)
      ST_IDLE:   if (tick_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (buffer_empty && grid_drained) begin
                   state_d  = ST_SETTLE;
                   settle_d = '0;
                 end
      // Any dip in grid_drained restarts the wait from DRAIN.
      ST_SETTLE: if (!grid_drained)                          state_d  = ST_DRAIN;
                 else if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d  = ST_TICK;
                 else                                         settle_d = settle_q + SW'(1);
      ST_TICK:   begin
                   state_d = ST_GAP;
                   gap_d   = '0;
                 end
      ST_GAP:    if (gap_q == GW'(TICK_GAP_CYCLES - 1)) state_d = ST_IDLE;
                 else                                     gap_d   = gap_q + GW'(1);
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      gap_q        <= '0;
      in_ready_q   <= 1'b1;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      tick_count_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      gap_q        <= gap_d;
      in_ready_q   <= (state_d == ST_IDLE) && !full_next;
      tick_q       <= (state_d == ST_TICK);
      busy_q       <= (state_d != ST_IDLE);
      tick_count_q <= tick_count_q + TICK_CNT_W'(state_d == ST_TICK);
      if (ren && buffer_empty) underflow_q <= 1'b1;
    end
  end

  assign in_ready        = in_ready_q;
  assign tick            = tick_q;
  assign busy            = busy_q;
  assign tick_count      = tick_count_q;
  assign underflow_error = underflow_q;

endmodule
